// File: rtl/micron_psram_responder.sv
// micron_psram_responder
// Device-side responder for the MT45W8 pseudo-SRAM pin interface. It latches a
// burst address, holds mwait for the access latency, then streams read data
// out of, or absorbs write data into, a small internal array.
// Optional feature: define MICRON_PSRAM_BCR_EN to make address phases with
// mcre=1 and mwe_L=0 load the latency code from maddr[13:11].
// Everything runs on clk50MHz; the gated device clock is never used as a clock.
module micron_psram_responder #(
   parameter int A_WIDTH    = 24,
   parameter int D_WIDTH    = 16,
   parameter int MEM_AW     = 8,
   parameter int RW_LATENCY = 4
) (
   input  logic               clk50MHz,
   input  logic               rst_L,
   input  logic [A_WIDTH-1:0] maddr,
   input  logic [D_WIDTH-1:0] mdata_in,
   output logic [D_WIDTH-1:0] mdata_out,
   output logic               mdata_oe,
   input  logic               moe_L,
   input  logic               mwe_L,
   input  logic               madv_L,
   input  logic               mce_L,
   input  logic               mcre,
   output logic               mwait
);

   typedef enum logic [1:0] {IDLE, LATENCY, READ, WRITE} state_t;

   localparam logic [2:0]        RESET_LAT = 3'(RW_LATENCY);
   localparam logic [MEM_AW-1:0] ADDR_ONE  = MEM_AW'(1);

   state_t              state;
   logic                op_write;
   logic [MEM_AW-1:0]   addr_q;
   logic [2:0]          lat_cnt;
   logic [2:0]          lat;
   logic                cfg_phase;
   logic                addr_phase;
   logic                mem_we;
   logic [D_WIDTH-1:0]  mem [0:(2**MEM_AW)-1];

   // Only the low index bits of maddr address the array; the rest (and mcre in
   // the default build) are intentionally ignored.
   logic unused_inputs;
   assign unused_inputs = ^{mcre, maddr};

   assign addr_phase = !mce_L && !madv_L;

`ifdef MICRON_PSRAM_BCR_EN
   assign cfg_phase = mcre;

   // Configuration register: holds the access latency code, clamped to >= 2.
   always_ff @(posedge clk50MHz or negedge rst_L) begin
      if (!rst_L)
         lat <= RESET_LAT;
      else if (addr_phase && mcre && !mwe_L)
         lat <= (maddr[13:11] < 3'd2) ? 3'd2 : maddr[13:11];
   end
`else
   assign cfg_phase = 1'b0;
   assign lat       = RESET_LAT;
`endif

   // Array writes happen only in WRITE with the chip still selected and no new
   // address phase aborting the burst on that edge.
   assign mem_we = (state == WRITE) && !mce_L && madv_L;

   // Read data is driven only while streaming and the controller enables output.
   assign mdata_oe = (state == READ) && !moe_L;

   // Access sequencer: address phase, latency countdown, then burst streaming.
   always_ff @(posedge clk50MHz or negedge rst_L) begin
      // NOTE: all state registers use non-blocking assignment so every branch
      // sees the pre-edge values of addr_q, lat_cnt and state.
      if (!rst_L) begin
         state     <= IDLE;
         op_write  <= 1'b0;
         addr_q    <= '0;
         lat_cnt   <= '0;
         mwait     <= 1'b0;
         mdata_out <= '0;
      end else if (mce_L) begin
         state <= IDLE;
         mwait <= 1'b0;
      end else if (!madv_L) begin
         if (cfg_phase) begin
            state <= IDLE;
            mwait <= 1'b0;
         end else begin
            addr_q   <= maddr[MEM_AW-1:0];
            op_write <= !mwe_L;
            lat_cnt  <= lat - 3'd1;
            state    <= LATENCY;
            mwait    <= 1'b1;
         end
      end else begin
         case (state)
            LATENCY: begin
               if (lat_cnt == 3'd0) begin
                  state <= op_write ? WRITE : READ;
                  mwait <= 1'b0;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            READ: begin
               mdata_out <= mem[addr_q];
               addr_q    <= addr_q + ADDR_ONE;
            end
            WRITE: begin
               addr_q <= addr_q + ADDR_ONE;
            end
            default: ;
         endcase
      end
   end

   // Storage array, written one word per cycle during a write burst.
   always_ff @(posedge clk50MHz) begin
      // NOTE: the array has no reset; its contents survive rst_L, and leaving
      // it out of the reset lets it map onto plain RAM.
      if (mem_we)
         mem[addr_q] <= mdata_in;
   end

endmodule

// File: tb/tb_micron_psram_responder.sv
// tb_micron_psram_responder
// Directed bench for micron_psram_responder: reset, write/read bursts, address
// wrap, chip-enable abort, mid-burst reset and latency configuration. Works for
// both the default build and builds with MICRON_PSRAM_BCR_EN defined.
module tb_micron_psram_responder;

`ifdef MICRON_PSRAM_BCR_EN
   localparam bit BCR = 1'b1;
`else
   localparam bit BCR = 1'b0;
`endif

   logic        clk50MHz;
   logic        rst_L;
   logic [23:0] maddr;
   logic [15:0] mdata_in;
   logic [15:0] mdata_out;
   logic        mdata_oe;
   logic        moe_L;
   logic        mwe_L;
   logic        madv_L;
   logic        mce_L;
   logic        mcre;
   logic        mwait;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          lat_n;
   logic [15:0] q [8];
   logic        oe_q [8];
   logic        oe_lat;
   logic        oe_end;
   logic        wait_end;

   micron_psram_responder #(
      .A_WIDTH(24), .D_WIDTH(16), .MEM_AW(8), .RW_LATENCY(4)
   ) dut (
      .clk50MHz (clk50MHz),
      .rst_L    (rst_L),
      .maddr    (maddr),
      .mdata_in (mdata_in),
      .mdata_out(mdata_out),
      .mdata_oe (mdata_oe),
      .moe_L    (moe_L),
      .mwe_L    (mwe_L),
      .madv_L   (madv_L),
      .mce_L    (mce_L),
      .mcre     (mcre),
      .mwait    (mwait)
   );

   initial begin
      clk50MHz = 1'b0;
      forever #10 clk50MHz = ~clk50MHz;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one edge and settle just after it.
   task automatic cycle();
      @(posedge clk50MHz);
      #1;
   endtask

   // Drive an address phase across one edge, then return the strobes to idle.
   task automatic addr_phase(input logic [23:0] a, input logic we, input logic cre);
      mce_L  = 1'b0;
      madv_L = 1'b0;
      mwe_L  = ~we;
      mcre   = cre;
      maddr  = a;
      cycle();
      madv_L = 1'b1;
      mwe_L  = 1'b1;
      mcre   = 1'b0;
   endtask

   // Count post-edge samples with mwait high, bounded to 16.
   task automatic count_wait(output int n);
      n = 0;
      while (mwait === 1'b1 && n < 16) begin
         n++;
         cycle();
      end
   endtask

   // Write burst of n sequential words starting at d0.
   task automatic do_write(input logic [23:0] a, input logic [15:0] d0, input int n,
                           output int lat_seen);
      addr_phase(a, 1'b1, 1'b0);
      count_wait(lat_seen);
      for (int i = 0; i < n; i++) begin
         mdata_in = d0 + 16'(i);
         cycle();
      end
      mce_L = 1'b1;
      cycle();
   endtask

   // Read burst of n words into q/oe_q; also records oe during latency and after.
   task automatic do_read(input logic [23:0] a, input int n, output int lat_seen);
      moe_L = 1'b0;
      addr_phase(a, 1'b0, 1'b0);
      oe_lat = mdata_oe;
      count_wait(lat_seen);
      for (int i = 0; i < n; i++) begin
         cycle();
         q[i]    = mdata_out;
         oe_q[i] = mdata_oe;
      end
      mce_L = 1'b1;
      cycle();
      oe_end   = mdata_oe;
      wait_end = mwait;
      moe_L    = 1'b1;
   endtask

   task automatic test_reset();
      rst_L    = 1'b0;
      maddr    = '0;
      mdata_in = '0;
      moe_L    = 1'b0;
      mwe_L    = 1'b1;
      madv_L   = 1'b1;
      mce_L    = 1'b1;
      mcre     = 1'b0;
      repeat (2) cycle();
      n_cmp++; if (mwait !== 1'b0) begin n_bad++; $display("FAIL reset_mwait: got %b want 0", mwait); end
      n_cmp++; if (mdata_out !== 16'h0000) begin n_bad++; $display("FAIL reset_mdata_out: got %h want 0000", mdata_out); end
      n_cmp++; if (mdata_oe !== 1'b0) begin n_bad++; $display("FAIL reset_mdata_oe: got %b want 0", mdata_oe); end
      #9 rst_L = 1'b1;
      cycle();
      n_cmp++; if (mdata_oe !== 1'b0 || mwait !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got oe=%b wait=%b want 0/0", mdata_oe, mwait); end
      moe_L = 1'b1;
   endtask

   task automatic test_write_burst();
      do_write(24'h000010, 16'hA000, 4, lat_n);
      n_cmp++; if (lat_n !== 4) begin n_bad++; $display("FAIL write_latency: got %0d want 4", lat_n); end
   endtask

   task automatic test_read_burst();
      do_read(24'h000010, 4, lat_n);
      n_cmp++; if (lat_n !== 4) begin n_bad++; $display("FAIL read_latency: got %0d want 4", lat_n); end
      n_cmp++; if (oe_lat !== 1'b0) begin n_bad++; $display("FAIL read_oe_in_latency: got %b want 0", oe_lat); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (q[i] !== 16'hA000 + 16'(i)) begin n_bad++; $display("FAIL read_word%0d: got %h want %h", i, q[i], 16'hA000 + 16'(i)); end
         n_cmp++; if (oe_q[i] !== 1'b1) begin n_bad++; $display("FAIL read_oe%0d: got %b want 1", i, oe_q[i]); end
      end
      n_cmp++; if (oe_end !== 1'b0 || wait_end !== 1'b0) begin n_bad++; $display("FAIL read_end_idle: got oe=%b wait=%b want 0/0", oe_end, wait_end); end
   endtask

   task automatic test_wrap();
      // Upper address bits set on the write must be ignored.
      do_write(24'h1200FF, 16'hB0FF, 2, lat_n);
      do_read(24'h0000FF, 2, lat_n);
      n_cmp++; if (q[0] !== 16'hB0FF) begin n_bad++; $display("FAIL wrap_word_ff: got %h want B0FF", q[0]); end
      n_cmp++; if (q[1] !== 16'hB100) begin n_bad++; $display("FAIL wrap_word_00: got %h want B100", q[1]); end
   endtask

   task automatic test_abort_write();
      do_write(24'h000022, 16'h5555, 1, lat_n);
      addr_phase(24'h000020, 1'b1, 1'b0);
      count_wait(lat_n);
      mdata_in = 16'hC000; cycle();
      mdata_in = 16'hC001; cycle();
      mdata_in = 16'hC002;
      mce_L    = 1'b1;
      moe_L    = 1'b0;
      cycle();
      n_cmp++; if (mwait !== 1'b0 || mdata_oe !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got wait=%b oe=%b want 0/0", mwait, mdata_oe); end
      moe_L = 1'b1;
      cycle();
      do_read(24'h000020, 3, lat_n);
      n_cmp++; if (q[0] !== 16'hC000) begin n_bad++; $display("FAIL abort_word0: got %h want C000", q[0]); end
      n_cmp++; if (q[1] !== 16'hC001) begin n_bad++; $display("FAIL abort_word1: got %h want C001", q[1]); end
      n_cmp++; if (q[2] !== 16'h5555) begin n_bad++; $display("FAIL abort_word2_unwritten: got %h want 5555", q[2]); end
   endtask

   task automatic test_reset_mid_read();
      moe_L = 1'b0;
      addr_phase(24'h000010, 1'b0, 1'b0);
      count_wait(lat_n);
      cycle();
      cycle();
      n_cmp++; if (mdata_out !== 16'hA001 || mdata_oe !== 1'b1) begin n_bad++; $display("FAIL midread_before_reset: got %h oe=%b want A001 oe=1", mdata_out, mdata_oe); end
      #5 rst_L = 1'b0;
      #1;
      n_cmp++; if (mdata_out !== 16'h0000) begin n_bad++; $display("FAIL midread_reset_data: got %h want 0000", mdata_out); end
      n_cmp++; if (mdata_oe !== 1'b0 || mwait !== 1'b0) begin n_bad++; $display("FAIL midread_reset_ctrl: got oe=%b wait=%b want 0/0", mdata_oe, mwait); end
      mce_L = 1'b1;
      moe_L = 1'b1;
      #3 rst_L = 1'b1;
      cycle();
   endtask

   task automatic test_latency_config();
      // Config write code 6 (default build: normal write of D00D to 0x00).
      addr_phase(24'h003000, 1'b1, 1'b1);
      count_wait(lat_n);
      n_cmp++; if (lat_n !== (BCR ? 0 : 4)) begin n_bad++; $display("FAIL cfg6_wait: got %0d want %0d", lat_n, BCR ? 0 : 4); end
      mdata_in = 16'hD00D; cycle();
      mce_L = 1'b1; cycle();
      do_read(24'h000000, 1, lat_n);
      n_cmp++; if (lat_n !== (BCR ? 6 : 4)) begin n_bad++; $display("FAIL cfg6_latency: got %0d want %0d", lat_n, BCR ? 6 : 4); end
      n_cmp++; if (q[0] !== (BCR ? 16'hB100 : 16'hD00D)) begin n_bad++; $display("FAIL cfg6_array: got %h want %h", q[0], BCR ? 16'hB100 : 16'hD00D); end

      // Config code 1 clamps to 2.
      addr_phase(24'h000800, 1'b1, 1'b1);
      count_wait(lat_n);
      mdata_in = 16'hD0E1; cycle();
      mce_L = 1'b1; cycle();
      do_read(24'h000000, 1, lat_n);
      n_cmp++; if (lat_n !== (BCR ? 2 : 4)) begin n_bad++; $display("FAIL cfg1_latency: got %0d want %0d", lat_n, BCR ? 2 : 4); end
      n_cmp++; if (q[0] !== (BCR ? 16'hB100 : 16'hD0E1)) begin n_bad++; $display("FAIL cfg1_array: got %h want %h", q[0], BCR ? 16'hB100 : 16'hD0E1); end

      // mcre with mwe_L=1 is ignored in the config build (a plain read otherwise).
      addr_phase(24'h001800, 1'b0, 1'b1);
      count_wait(lat_n);
      n_cmp++; if (lat_n !== (BCR ? 0 : 4)) begin n_bad++; $display("FAIL cfg_read_ignored_wait: got %0d want %0d", lat_n, BCR ? 0 : 4); end
      mce_L = 1'b1; cycle();
      do_read(24'h000000, 1, lat_n);
      n_cmp++; if (lat_n !== (BCR ? 2 : 4)) begin n_bad++; $display("FAIL cfg_read_ignored_latency: got %0d want %0d", lat_n, BCR ? 2 : 4); end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_read_burst();
      test_wrap();
      test_abort_write();
      test_reset_mid_read();
      test_latency_config();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/micron_psram_responder.md
# micron_psram_responder

- Synthesizable responder model of the Micron MT45W8 pseudo-SRAM device, driven by the PSRAM controller over the same pin-level signals.
- Latches a burst address, holds `mwait` for the configured latency, then streams read data or absorbs write data from a small internal array.
- Used in on-chip loopback builds and benches as the device end of the memory interface.
- Runs on the controller's source clock; the gated device clock is not used as a clock.

## Interface
Parameters:
- A_WIDTH, 24, address bus width
- D_WIDTH, 16, data word width
- MEM_AW, 8, index bits of internal array (2^MEM_AW words)
- RW_LATENCY, 4, reset/default access latency in cycles (2..7)

Ports:
- clk50MHz  input  1  system clock; all state changes on rising edge
- rst_L  input  1  asynchronous active-low reset
- maddr  input  A_WIDTH  burst start address / config word
- mdata_in  input  D_WIDTH  write data from controller
- mdata_out  output  D_WIDTH  read data (registered)
- mdata_oe  output  1  read data drive enable
- moe_L  input  1  output enable, active low
- mwe_L  input  1  write enable, active low, sampled with address
- madv_L  input  1  address valid, active low
- mce_L  input  1  chip enable, active low
- mcre  input  1  control register enable, active high
- mwait  output  1  high while access latency is pending

## Operation
- States: IDLE, LATENCY, READ, WRITE.
- Address phase: edge where `mce_L`=0 and `madv_L`=0.
  - Latch `addr_q` = maddr[MEM_AW-1:0] and op = write when `mwe_L`=0.
  - Load latency counter with lat-1.
  - Enter LATENCY; `mwait`=1.
- LATENCY: counter decrements each edge. The edge where it reads 0 enters READ (op read) or WRITE (op write) and clears `mwait`.
- READ, each edge:
  - `mdata_out` <= mem[addr_q].
  - `addr_q` <= addr_q+1.
  - `mdata_oe` = (state==READ) & ~moe_L, combinational.
- WRITE, each edge: mem[addr_q] <= mdata_in; `addr_q` <= addr_q+1.
- Bursts are unbounded: continue until `mce_L`=1. `addr_q` wraps modulo 2^MEM_AW; upper address bits are ignored.
- `mce_L`=1 at any edge, any state: next state IDLE, `mwait`=0, no array write on that edge. This has priority over all other inputs.
- `madv_L`=0 with `mce_L`=0 in LATENCY/READ/WRITE: aborts the burst and starts a new address phase (re-latch, reload counter).
- Array contents are not reset.

## Timing
- Reset values: state IDLE, `mwait`=0, `mdata_out`=0, `mdata_oe`=0, `addr_q`=0, lat=RW_LATENCY. Reset mid-burst returns to IDLE immediately; no further writes.
- Address phase at edge E0: `mwait` high after E0, low after edge E0+lat.
- Read: first word valid after edge E0+lat+1; one word per cycle thereafter.
- Write: first word written at edge E0+lat+1 from `mdata_in` sampled on that edge.
- The lat value used is the one in effect at E0.

## Configuration
- Macro: `MICRON_PSRAM_BCR_EN`.
- Defined: address phase with `mcre`=1 and `mwe_L`=0 is a config write.
  - lat <= maddr[13:11]; codes 0 and 1 clamp to 2.
  - Stays IDLE; `mwait` not asserted; array untouched.
  - `mcre`=1 with `mwe_L`=1 is ignored, stays IDLE.
- Not defined: `mcre` is ignored; every address phase is a normal access; lat fixed at RW_LATENCY.

## Test plan
- Reset, then write burst at addr 0x10 with data 0xA000..0xA003, lat 4 → `mwait` high exactly 4 cycles; mem[0x10..0x13] = 0xA000..0xA003.
- Read burst at 0x10, `moe_L`=0 → `mwait` 4 cycles, then `mdata_out` = 0xA000, 0xA001, 0xA002, 0xA003 on consecutive cycles; `mdata_oe`=1 only in READ.
- Write 2 words at 0xFF with MEM_AW=8 → words land at 0xFF and 0x00 (wrap).
- `mce_L` raised during third word of a write burst → third word not written, IDLE next cycle, `mwait`=0; `rst_L` pulsed mid-read → `mdata_out`=0, `mdata_oe`=0 immediately.
- With `MICRON_PSRAM_BCR_EN`: config write maddr[13:11]=6, then read → `mwait` high 6 cycles; config code 1 → 2 cycles. Without the macro: same stimulus → 4 cycles, and the config write is treated as an array write.
